// File: rtl/rv32i_lsu.sv
// rv32i_lsu: RV32I load/store unit between the execute stage and a registered-read data RAM.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of dropping the low address bits.
module rv32i_lsu #(
    parameter int ADDR_BITS = 30
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_width,
    input  logic                 req_sign,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [4:0]           req_rd,
    output logic [ADDR_BITS-1:0] d_addr,
    output logic                 d_we,
    output logic [3:0]           d_be,
    output logic [31:0]          d_wdata,
    input  logic [31:0]          d_rdata,
    output logic                 wb_valid,
    output logic [4:0]           wb_rd,
    output logic [31:0]          wb_data,
    output logic                 fault
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FAULT} state_e;

    function automatic logic [3:0] byte_en(input logic [1:0] width, input logic [1:0] lo);
        case (width)
            2'b00:   byte_en = 4'b0001 << lo;
            2'b01:   byte_en = lo[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] width, input logic [31:0] wdata);
        case (width)
            2'b00:   store_lanes = {4{wdata[7:0]}};
            2'b01:   store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [1:0] width,
                                               input logic [1:0] lo, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lo, 3'b000} +: 8];
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (width)
            2'b00:   load_align = {{24{sgn & b[7]}}, b};
            2'b01:   load_align = {{16{sgn & h[15]}}, h};
            default: load_align = rdata;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lo);
        case (width)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lo[0];
            default: misaligned = |lo;
        endcase
    endfunction

    state_e                state_q;
    logic                  we_q;
    logic                  sign_q;
    logic [1:0]            width_q;
    logic [1:0]            lo_q;
    logic [4:0]            rd_q;
    logic [ADDR_BITS-1:0]  d_addr_q;
    logic                  d_we_q;
    logic [3:0]            d_be_q;
    logic [31:0]           d_wdata_q;
    logic                  wb_valid_q;
    logic [4:0]            wb_rd_q;
    logic [31:0]           wb_data_q;
    logic                  fault_q;

    logic [3:0]            be_d;
    logic [31:0]           wdata_d;
    logic [31:0]           wb_data_d;
    logic                  trap_d;

    always_comb begin
        be_d      = byte_en(req_width, req_addr[1:0]);
        wdata_d   = store_lanes(req_width, req_wdata);
        wb_data_d = load_align(d_rdata, width_q, lo_q, sign_q);
        trap_d    = TRAP_EN && misaligned(req_width, req_addr[1:0]);
    end

    // RAM strobes live only in ISSUE; wb_valid and fault are one-cycle pulses by default-clearing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            sign_q     <= 1'b0;
            width_q    <= 2'b00;
            lo_q       <= 2'b00;
            rd_q       <= 5'd0;
            d_addr_q   <= '0;
            d_we_q     <= 1'b0;
            d_be_q     <= 4'b0000;
            d_wdata_q  <= 32'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        sign_q  <= req_sign;
                        width_q <= req_width;
                        lo_q    <= req_addr[1:0];
                        rd_q    <= req_rd;
                        if (trap_d) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q   <= ISSUE;
                            d_addr_q  <= req_addr[ADDR_BITS+1:2];
                            d_we_q    <= req_we;
                            d_be_q    <= be_d;
                            d_wdata_q <= wdata_d;
                        end
                    end
                end
                ISSUE: begin
                    d_we_q  <= 1'b0;
                    d_be_q  <= 4'b0000;
                    state_q <= we_q ? IDLE : WAIT;
                end
                WAIT: begin
                    wb_valid_q <= 1'b1;
                    wb_data_q  <= wb_data_d;
                    wb_rd_q    <= rd_q;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gate ready with reset so every output reads 0 while reset_n is held low.
    assign req_ready = reset_n && (state_q == IDLE);
    assign d_addr    = d_addr_q;
    assign d_we      = d_we_q;
    assign d_be      = d_be_q;
    assign d_wdata   = d_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign fault     = TRAP_EN ? fault_q : 1'b0;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: literal scenario checks plus randomized traffic against a byte-array memory model.
module tb_rv32i_lsu;

    localparam int AB    = 30;
    localparam int DEPTH = 8192;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_width = 2'b00;
    logic          req_sign = 1'b0;
    logic [31:0]   req_addr = 32'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic [4:0]    req_rd = 5'd0;
    logic [AB-1:0] d_addr;
    logic          d_we;
    logic [3:0]    d_be;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          fault;

    rv32i_lsu #(.ADDR_BITS(AB)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_width(req_width), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
    );

    always #5 clk = ~clk;

    // Data RAM with registered read, aliased to 256 words.
    bit [31:0] ram [256];
    always @(posedge clk) begin
        if (d_we)
            for (int k = 0; k < 4; k++)
                if (d_be[k]) ram[d_addr[7:0]][8*k +: 8] <= d_wdata[8*k +: 8];
        d_rdata <= ram[d_addr[7:0]];
    end

    // Reference: byte memory plus per-cycle expectations indexed by cycle number.
    bit [7:0]  ref_mem [1024];
    bit        e_busy [DEPTH];
    bit        e_iss  [DEPTH];
    bit        e_we   [DEPTH];
    bit        e_wbv  [DEPTH];
    bit        e_flt  [DEPTH];
    bit [3:0]  e_be   [DEPTH];
    bit [29:0] e_addr [DEPTH];
    bit [31:0] e_wd   [DEPTH];
    bit [31:0] e_wbd  [DEPTH];
    bit [4:0]  e_wbrd [DEPTH];

    logic [31:0] held_data = 32'd0;
    logic [4:0]  held_rd = 5'd0;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int size_of(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] w, input logic s);
        int sz;
        int base;
        longint v;
        sz = size_of(w);
        base = int'(a[9:0]) & ~(sz - 1);
        v = 0;
        for (int i = 0; i < sz; i++) v |= longint'(ref_mem[base + i]) << (8 * i);
        if (s && v[8*sz-1]) v |= ~((longint'(1) << (8 * sz)) - 1);
        return v[31:0];
    endfunction

    always @(negedge clk) begin : cmp
        logic [31:0] xd;
        logic [4:0]  xr;
        if (cyc < DEPTH) begin
            if (!reset_n) begin
                xd = 32'd0; xr = 5'd0;
            end else if (e_wbv[cyc]) begin
                xd = e_wbd[cyc]; xr = e_wbrd[cyc];
            end else begin
                xd = held_data; xr = held_rd;
            end
            held_data <= xd;
            held_rd   <= xr;
            chk("req_ready", 32'(req_ready), 32'(reset_n && !e_busy[cyc]));
            chk("d_we", 32'(d_we), 32'(e_we[cyc]));
            chk("d_be", 32'(d_be), 32'(e_be[cyc]));
            if (e_iss[cyc]) chk("d_addr", 32'(d_addr), 32'(e_addr[cyc]));
            if (e_we[cyc]) chk("d_wdata", d_wdata, e_wd[cyc]);
            chk("wb_valid", 32'(wb_valid), 32'(e_wbv[cyc]));
            chk("wb_data", wb_data, xd);
            chk("wb_rd", 32'(wb_rd), 32'(xr));
            chk("fault", 32'(fault), 32'(e_flt[cyc]));
            chk("we_with_wbv", 32'(d_we & wb_valid), 32'd0);
        end
    end

    // Called just after a falling edge with the DUT idle; returns just after a falling edge with it idle again.
    task automatic do_req(input logic we, input logic [1:0] w, input logic s, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          output logic [31:0] i_addr, output logic [31:0] i_be, output logic [31:0] i_wd,
                          output logic i_we, output logic i_flt, output logic [31:0] r_data,
                          output logic [4:0] r_rd, output logic r_vld, output logic [31:0] m_val);
        int c, sz, base;
        logic mis;
        logic [3:0] be;
        logic [31:0] lanes;
        c = cyc;
        sz = size_of(w);
        mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
        base = int'(a[9:0]) & ~(sz - 1);
        be = 4'b0000;
        for (int i = 0; i < sz; i++) be[(base + i) % 4] = 1'b1;
        for (int k = 0; k < 4; k++) lanes[8*k +: 8] = wd[8*(k % sz) +: 8];
        m_val = 32'd0;
        e_busy[c+1] = 1'b1;
        if (TRAP && mis) begin
            e_flt[c+1] = 1'b1;
        end else begin
            e_iss[c+1]  = 1'b1;
            e_be[c+1]   = be;
            e_addr[c+1] = a[31:2];
            if (we) begin
                e_we[c+1] = 1'b1;
                e_wd[c+1] = lanes;
                for (int i = 0; i < sz; i++) ref_mem[base + i] = wd[8*i +: 8];
            end else begin
                e_busy[c+2] = 1'b1;
                m_val = m_load(a, w, s);
                e_wbv[c+3]  = 1'b1;
                e_wbd[c+3]  = m_val;
                e_wbrd[c+3] = rd;
            end
        end
        req_valid = 1'b1; req_we = we; req_width = w; req_sign = s;
        req_addr = a; req_wdata = wd; req_rd = rd;
        @(posedge clk);
        #1;
        req_valid = 1'($urandom); req_we = 1'($urandom); req_width = 2'($urandom);
        req_sign = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        @(negedge clk);
        i_addr = 32'(d_addr); i_be = 32'(d_be); i_wd = d_wdata; i_we = d_we; i_flt = fault;
        r_data = 32'd0; r_rd = 5'd0; r_vld = 1'b0;
        if (!we && !(TRAP && mis)) begin
            @(negedge clk);
            @(negedge clk);
            r_data = wb_data; r_rd = wb_rd; r_vld = wb_valid;
        end else begin
            @(negedge clk);
        end
        #1 req_valid = 1'b0;
    endtask

    logic [31:0] ia, ibe, iwd, rr, mv;
    logic        iwe, iflt, rv;
    logic [4:0]  rrd;

    task automatic rnd_req();
        logic [31:0] a;
        a = $urandom;
        a[9:0] = 10'($urandom_range(0, 127));
        do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 5'($urandom),
               ia, ibe, iwd, iwe, iflt, rr, rrd, rv, mv);
        if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 2)) begin
                @(negedge clk);
                #1;
            end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        #1 chk("ready_after_reset", 32'(req_ready), 32'd1);
        @(negedge clk);
        #1;

        do_req(1'b1, 2'b00, 1'b0, 32'h50, 32'h80, 5'd0, ia, ibe, iwd, iwe, iflt, rr, rrd, rv, mv);
        chk("sb50_addr", ia, 32'h14);
        chk("sb50_be", ibe, 32'h1);
        chk("sb50_wdata", iwd, 32'h80808080);
        chk("sb50_we", 32'(iwe), 32'd1);

        do_req(1'b1, 2'b10, 1'b0, 32'h60, 32'h12345678, 5'd0, ia, ibe, iwd, iwe, iflt, rr, rrd, rv, mv);
        do_req(1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 5'd5, ia, ibe, iwd, iwe, iflt, rr, rrd, rv, mv);
        chk("lw60_valid", 32'(rv), 32'd1);
        chk("lw60_data", rr, 32'h12345678);
        chk("lw60_model", mv, 32'h12345678);
        chk("lw60_rd", 32'(rrd), 32'd5);

        do_req(1'b1, 2'b01, 1'b0, 32'h62, 32'h0000FFFB, 5'd0, ia, ibe, iwd, iwe, iflt, rr, rrd, rv, mv);
        chk("sh62_be", ibe, 32'hC);
        do_req(1'b0, 2'b01, 1'b1, 32'h62, 32'h0, 5'd3, ia, ibe, iwd, iwe, iflt, rr, rrd, rv, mv);
        chk("lh62_signed", rr, 32'hFFFFFFFB);
        do_req(1'b0, 2'b01, 1'b0, 32'h62, 32'h0, 5'd4, ia, ibe, iwd, iwe, iflt, rr, rrd, rv, mv);
        chk("lhu62_unsigned", rr, 32'h0000FFFB);

        do_req(1'b1, 2'b00, 1'b0, 32'h53, 32'h80, 5'd0, ia, ibe, iwd, iwe, iflt, rr, rrd, rv, mv);
        do_req(1'b0, 2'b00, 1'b1, 32'h53, 32'h0, 5'd17, ia, ibe, iwd, iwe, iflt, rr, rrd, rv, mv);
        chk("lb53_data", rr, 32'hFFFFFF80);
        chk("lb53_rd", 32'(rrd), 32'd17);

        do_req(1'b0, 2'b10, 1'b0, 32'h61, 32'h0, 5'd9, ia, ibe, iwd, iwe, iflt, rr, rrd, rv, mv);
`ifdef MISALIGN_TRAP_EN
        chk("lw61_fault", 32'(iflt), 32'd1);
        chk("lw61_be", ibe, 32'd0);
        chk("lw61_we", 32'(iwe), 32'd0);
`else
        chk("lw61_data", rr, 32'hFFFB5678);
        chk("lw61_model", mv, 32'hFFFB5678);
        chk("lw61_valid", 32'(rv), 32'd1);
`endif

        for (int n = 0; n < 500; n++) rnd_req();

        // Load dropped by reset while waiting on RAM data.
        c0 = cyc;
        e_busy[c0+1] = 1'b1; e_iss[c0+1] = 1'b1; e_be[c0+1] = 4'b1111;
        e_addr[c0+1] = 30'h18; e_busy[c0+2] = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_width = 2'b10; req_sign = 1'b0;
        req_addr = 32'h60; req_wdata = 32'd0; req_rd = 5'd7;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_d_we", 32'(d_we), 32'd0);
        chk("rst_d_be", 32'(d_be), 32'd0);
        chk("rst_d_addr", 32'(d_addr), 32'd0);
        chk("rst_d_wdata", d_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        #1 chk("rst_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        #1;

        for (int n = 0; n < 60; n++) rnd_req();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
